// File: rtl/ahb_burst_master_if.sv
// ahb_burst_master_if: AHB-Lite bus between the burst master and the bridge slave port
interface ahb_burst_master_if;
  logic [1:0] Htrans;
  logic [31:0] Haddr;
  logic Hwrite;
  logic [2:0] Hsize;
  logic [2:0] Hburst;
  logic [31:0] Hwdata;
  logic Hreadyin;
  logic [1:0] Hresp;
  logic [31:0] Hrdata;
  modport master(
    output Htrans, Haddr, Hwrite, Hsize, Hburst, Hwdata,
    input Hreadyin, Hresp, Hrdata
  );
  modport slave(
    input Htrans, Haddr, Hwrite, Hsize, Hburst, Hwdata,
    output Hreadyin, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite initiator issuing SINGLE/INCR word bursts from a local command port
module ahb_burst_master #(
  parameter int MAX_BEATS = 16,
  parameter int BOUNDARY = 1024
) (
  input logic Hclk,
  input logic Hresetn,
  input logic cmd_valid,
  output logic cmd_ready,
  input logic cmd_write,
  input logic [31:0] cmd_addr,
  input logic [4:0] cmd_len,
  output logic wdata_req,
  input logic [31:0] wdata,
  output logic rdata_valid,
  output logic [31:0] rdata,
  output logic done,
  output logic err,
  ahb_burst_master_if.master ahb
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, BURST = 3'd2, LAST = 3'd3, ERR = 3'd4;
  localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  logic [2:0] state;
  logic [CW-1:0] beats, len_c;
  logic dp, a_done, d_done, e_det, at_bound;
  logic [31:0] next_addr;
  assign ahb.Hsize = 3'b010;
  always_comb begin
    len_c = (cmd_len == 5'd0) ? CW'(1) : (32'(cmd_len) > 32'(MAX_BEATS)) ? CW'(MAX_BEATS) : CW'(cmd_len);
    a_done = ahb.Htrans[1] & ahb.Hreadyin;
    d_done = dp & ahb.Hreadyin;
    e_det = dp & ~ahb.Hreadyin & (ahb.Hresp != 2'b00);
    next_addr = ahb.Haddr + 32'd4;
    at_bound = (next_addr & 32'(BOUNDARY - 1)) == 32'd0;
    cmd_ready = (state == IDLE) & ~done;
    wdata_req = a_done & ahb.Hwrite;
  end
  // dp marks a data phase in flight; it overlaps the next address phase in a burst
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state <= IDLE;
      beats <= '0;
      dp <= 1'b0;
      ahb.Htrans <= T_IDLE;
      ahb.Haddr <= '0;
      ahb.Hwrite <= 1'b0;
      ahb.Hburst <= '0;
      ahb.Hwdata <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      rdata_valid <= 1'b0;
      if (e_det) begin
        state <= ERR;
        ahb.Htrans <= T_IDLE;
        dp <= 1'b0;
      end else if (state == ERR) begin
        if (ahb.Hreadyin) begin
          state <= IDLE;
          done <= 1'b1;
          err <= 1'b1;
        end
      end else begin
        dp <= a_done | (dp & ~ahb.Hreadyin);
        if (cmd_valid && cmd_ready) begin
          state <= ADDR;
          ahb.Htrans <= T_NONSEQ;
          ahb.Haddr <= cmd_addr & ~32'd3;
          ahb.Hwrite <= cmd_write;
          ahb.Hburst <= (len_c == CW'(1)) ? 3'b000 : 3'b001;
          beats <= len_c;
        end
        if (a_done) begin
          beats <= beats - CW'(1);
          ahb.Haddr <= next_addr;
          ahb.Hwdata <= ahb.Hwrite ? wdata : ahb.Hwdata;
          ahb.Htrans <= (beats == CW'(1)) ? T_IDLE : at_bound ? T_NONSEQ : T_SEQ;
          state <= (beats == CW'(1)) ? LAST : BURST;
        end
        if (d_done && !ahb.Hwrite) begin
          rdata <= ahb.Hrdata;
          rdata_valid <= 1'b1;
        end
        if (d_done && state == LAST) begin
          state <= IDLE;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: scoreboard bench with a reactive AHB slave model for ahb_burst_master
module tb_ahb_burst_master;
  logic clk = 1'b0, Hresetn = 1'b0, cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, wdata = '0;
  logic [4:0] cmd_len = '0;
  logic cmd_ready, wdata_req, rdata_valid, done, err;
  logic [31:0] rdata;
  ahb_burst_master_if bus();
  ahb_burst_master dut (
    .Hclk(clk), .Hresetn(Hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata_req(wdata_req),
    .wdata(wdata), .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err), .ahb(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [1:0] tr; logic [31:0] a; logic [2:0] b;} ap_t;
  ap_t q_addr[$];
  logic [31:0] q_rd[$], q_wd[$], wd_src[$];
  int n_tests = 0, n_fail = 0, cyc = 0, acc_cyc = 0, exp_lat = -1, dbeat = 0;
  int err_at = -1, stall_at = -1, stall_cnt = 0, done_cnt = 0, wreq_cnt = 0, rv_cnt = 0;
  int w0, r0, d0;
  logic exp_err = 1'b0, cur_wr = 1'b0, ign = 1'b0, dp_tb = 1'b0, e_phase = 1'b0, e_start = 1'b0;
  logic prev_stall = 1'b0, rdy, a_done, d_done;
  logic [1:0] rsp, p_tr;
  logic [31:0] p_a, p_wd;
  ap_t e;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic exp_burst(input logic [31:0] a, input int n, input logic [2:0] b);
    for (int i = 0; i < n; i++) begin
      q_addr.push_back('{(i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11, a, b});
      a += 32'd4;
    end
  endtask
  task automatic send(input logic w, input logic [31:0] a, input logic [4:0] l);
    int k;
    dbeat = 0;
    cur_wr = w;
    @(posedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_len = l;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done();
    int s;
    s = done_cnt;
    for (int i = 0; i < 300 && done_cnt == s; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    chk("done_count", 32'(done_cnt - s), 32'd1);
    chk("q_addr_empty", 32'(q_addr.size()), 32'd0);
    chk("q_rd_empty", 32'(q_rd.size()), 32'd0);
    chk("q_wd_empty", 32'(q_wd.size()), 32'd0);
  endtask
  initial begin
    bus.Hreadyin = 1'b1;
    bus.Hresp = 2'b00;
    bus.Hrdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      e_start = 1'b0;
      if (e_phase) begin
        rdy = 1'b1;
        rsp = 2'b01;
      end else if (dp_tb && dbeat == err_at) begin
        rdy = 1'b0;
        rsp = 2'b01;
        e_start = 1'b1;
      end else if (dp_tb && dbeat == stall_at && stall_cnt > 0) begin
        rdy = 1'b0;
        rsp = 2'b00;
        stall_cnt--;
      end else begin
        rdy = 1'b1;
        rsp = 2'b00;
      end
      bus.Hreadyin = rdy;
      bus.Hresp = rsp;
      bus.Hrdata = 32'hA0 + 32'(dbeat);
      wdata = (wd_src.size() > 0) ? wd_src[0] : 32'h0;
      #1;
      a_done = bus.Htrans[1] && rdy;
      d_done = dp_tb && rdy && rsp == 2'b00;
      if (!Hresetn) begin
        dp_tb = 1'b0;
        e_phase = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (!ign) begin
          if (e_phase) chk("err_htrans_idle", 32'(bus.Htrans), 32'd0);
          if (prev_stall) begin
            chk("hold_htrans", 32'(bus.Htrans), 32'(p_tr));
            chk("hold_haddr", bus.Haddr, p_a);
            chk("hold_hwdata", bus.Hwdata, p_wd);
          end
          if (a_done) begin
            e = (q_addr.size() > 0) ? q_addr.pop_front() : '0;
            chk("htrans", 32'(bus.Htrans), 32'(e.tr));
            chk("haddr", bus.Haddr, e.a);
            chk("hburst", 32'(bus.Hburst), 32'(e.b));
            chk("wdata_req", 32'(wdata_req), 32'(cur_wr));
            if (cur_wr) q_wd.push_back(wdata);
          end else chk("wdata_req_idle", 32'(wdata_req), 32'd0);
          if (d_done && cur_wr) chk("hwdata", bus.Hwdata, (q_wd.size() > 0) ? q_wd.pop_front() : 32'h5A5A_5A5A);
          if (rdata_valid) chk("rdata", rdata, (q_rd.size() > 0) ? q_rd.pop_front() : 32'hFFFF_FFFF);
          if (done) begin
            chk("err", 32'(err), 32'(exp_err));
            chk("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
            if (exp_lat > 0) chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
          end
        end
        if (a_done && cur_wr && wd_src.size() > 0) void'(wd_src.pop_front());
        if (wdata_req) wreq_cnt++;
        if (rdata_valid) rv_cnt++;
        if (done) done_cnt++;
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        prev_stall = !rdy && rsp == 2'b00;
        p_tr = bus.Htrans;
        p_a = bus.Haddr;
        p_wd = bus.Hwdata;
        if (d_done) dbeat++;
        if (e_phase) begin
          e_phase = 1'b0;
          dp_tb = 1'b0;
        end else if (e_start) begin
          e_phase = 1'b1;
          err_at = -1;
        end else if (a_done) dp_tb = 1'b1;
        else if (rdy) dp_tb = 1'b0;
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_htrans", 32'(bus.Htrans), 32'd0);
    chk("rst_haddr", bus.Haddr, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_wdata_req", 32'(wdata_req), 32'd0);
    #1 Hresetn = 1'b1;
    exp_lat = 3;
    wd_src.push_back(32'h1234_5678);
    q_addr.push_back('{2'b10, 32'h8000_0010, 3'b000});
    send(1'b1, 32'h8000_0010, 5'd1);
    wait_done();
    exp_lat = -1;
    exp_burst(32'h8400_0020, 4, 3'b001);
    for (int i = 0; i < 4; i++) q_rd.push_back(32'hA0 + 32'(i));
    send(1'b0, 32'h8400_0020, 5'd4);
    wait_done();
    stall_at = 1;
    stall_cnt = 2;
    w0 = wreq_cnt;
    exp_burst(32'h8000_0100, 3, 3'b001);
    wd_src.push_back(32'h1111_1111);
    wd_src.push_back(32'h2222_2222);
    wd_src.push_back(32'h3333_3333);
    send(1'b1, 32'h8000_0100, 5'd3);
    wait_done();
    chk("wreq_pulses", 32'(wreq_cnt - w0), 32'd3);
    chk("stall_used", 32'(stall_cnt), 32'd0);
    stall_at = -1;
    q_addr.push_back('{2'b10, 32'h8000_03F8, 3'b001});
    q_addr.push_back('{2'b11, 32'h8000_03FC, 3'b001});
    q_addr.push_back('{2'b10, 32'h8000_0400, 3'b001});
    q_addr.push_back('{2'b11, 32'h8000_0404, 3'b001});
    for (int i = 0; i < 4; i++) q_rd.push_back(32'hA0 + 32'(i));
    send(1'b0, 32'h8000_03F8, 5'd4);
    wait_done();
    err_at = 1;
    exp_err = 1'b1;
    r0 = rv_cnt;
    q_addr.push_back('{2'b10, 32'h8000_0200, 3'b001});
    q_addr.push_back('{2'b11, 32'h8000_0204, 3'b001});
    q_rd.push_back(32'hA0);
    send(1'b0, 32'h8000_0200, 5'd4);
    wait_done();
    chk("err_rvalid_count", 32'(rv_cnt - r0), 32'd1);
    exp_err = 1'b0;
    exp_lat = 3;
    q_addr.push_back('{2'b10, 32'h8000_0010, 3'b000});
    wd_src.push_back(32'hCAFE_F00D);
    send(1'b1, 32'h8000_0013, 5'd0);
    wait_done();
    exp_lat = -1;
    exp_burst(32'h8000_0040, 16, 3'b001);
    for (int i = 0; i < 16; i++) q_rd.push_back(32'hA0 + 32'(i));
    send(1'b0, 32'h8000_0040, 5'd20);
    wait_done();
    ign = 1'b1;
    send(1'b0, 32'h8000_0300, 5'd8);
    repeat (2) @(posedge clk);
    #2 Hresetn = 1'b0;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    chk("midrst_htrans", 32'(bus.Htrans), 32'd0);
    chk("midrst_haddr", bus.Haddr, 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    #1 Hresetn = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_idle_htrans", 32'(bus.Htrans), 32'd0);
    ign = 1'b0;
    exp_burst(32'h8000_0080, 1, 3'b000);
    q_rd.push_back(32'hA0);
    send(1'b0, 32'h8000_0080, 5'd1);
    wait_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_burst_master.md
Name: ahb_burst_master

Overview:
AHB-Lite initiator that drives the bridge's AHB slave port (Htrans/Haddr/Hwrite/Hwdata) from a simple local command interface. It issues single or incrementing word bursts of 1..MAX_BEATS beats and honours Hreadyin wait states and the Hresp ERROR response. Read data is returned on a valid-strobed stream. It serves as the system-side traffic source for bridge integration and for the bridge's own self-checking benches.

Parameters:
MAX_BEATS, 16, maximum beats per command; cmd_len values above this are clamped to MAX_BEATS.
BOUNDARY, 1024, byte boundary an INCR burst must not cross; the burst restarts with NONSEQ at the boundary.

Ports:
Hclk  in  1  system clock; all logic is on the rising edge.
Hresetn  in  1  synchronous active-low reset, sampled on the Hclk rising edge.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  32  start byte address; bits [1:0] are ignored and forced to 0.
cmd_len  in  5  beat count; 0 is treated as 1.
wdata_req  out  1  pulses when a write beat's address phase completes; wdata is consumed at that edge.
wdata  in  32  write data for the beat named by wdata_req.
rdata_valid  out  1  one-cycle strobe for each completed read beat.
rdata  out  32  registered copy of Hrdata.
done  out  1  one-cycle pulse when a command finishes.
err  out  1  qualifies done: 1 = burst aborted by ERROR.
Htrans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ.
Haddr  out  32  beat address.
Hwrite  out  1  transfer direction.
Hsize  out  3  constant 3'b010 (word).
Hburst  out  3  000 SINGLE when len = 1, 001 INCR otherwise.
Hwdata  out  32  write data, driven during the data phase.
Hreadyin  in  1  slave ready.
Hresp  in  2  00 OKAY, 01 ERROR.
Hrdata  in  32  read data.

Behaviour:
- Reset: while Hresetn = 0 at a clock edge, all outputs go to 0 except cmd_ready = 1. Htrans = IDLE. The FSM returns to IDLE and beat counters clear. Reset mid-burst abandons the burst with no done pulse.
- FSM states: IDLE, ADDR, BURST, LAST, ERR.
- IDLE: on command acceptance, the next cycle is ADDR with Htrans = NONSEQ, Haddr = cmd_addr, and Hwrite/Hburst from the command. Command fields are latched.
- Address phase completes on an edge where Htrans is NONSEQ or SEQ and Hreadyin = 1. At that edge:
  - the beat counter decrements;
  - Haddr advances by 4;
  - for writes, wdata is registered into Hwdata and wdata_req is high that cycle (combinational from the completion condition).
- ADDR/BURST: while beats remain, the next address phase is SEQ and overlaps the previous data phase. After the last address completes, go to LAST with Htrans = IDLE.
- Hreadyin = 0: Htrans, Haddr, Hwrite and Hwdata hold their values unchanged.
- Boundary crossing: if the next address is a multiple of BOUNDARY (e.g. 0x8000_0400), that beat is issued as NONSEQ instead of SEQ. The counter continues; this is not a new command.
- Data phase completes on an edge where Hreadyin = 1 for an outstanding beat. For reads, rdata <= Hrdata and rdata_valid = 1 the following cycle.
- LAST: the final data phase completes, then done = 1 with err = 0 for one cycle, then IDLE. Minimum latency from acceptance to done for a single zero-wait beat is 3 cycles.
- ERROR response, detected when Hresp = 01 and Hreadyin = 0 during a data phase:
  - in the next cycle Htrans is forced to IDLE, cancelling any pending address phase;
  - the FSM goes to ERR and waits for the Hreadyin = 1 second error cycle;
  - then done = 1, err = 1, and the FSM returns to IDLE;
  - no rdata_valid is produced for the errored beat or any later beat.
- Simultaneous events: cmd_valid while not in IDLE is ignored (cmd_ready = 0). A command can be accepted in the cycle after done.
- Hresp = 1x (RETRY/SPLIT) is treated as ERROR.

Test Plan:
- Reset, then single write: cmd_addr 0x8000_0010, len 1, wdata 0x1234_5678, Hreadyin = 1 -> NONSEQ at 0x8000_0010, Hburst 000, Hwdata 0x1234_5678 one cycle later, done 3 cycles after acceptance, err = 0.
- 4-beat read at 0x8400_0020 with Hrdata 0xA0..0xA3 -> NONSEQ then SEQ×3 at 0x20/24/28/2C, Hburst 001, four rdata_valid pulses carrying 0xA0..0xA3 in order.
- 3-beat write with Hreadyin held low for 2 cycles during beat 2 -> Htrans, Haddr and Hwdata stable across the stall, exactly 3 wdata_req pulses, done once.
- Burst from 0x8000_03F8, len 4 -> addresses 3F8 (NONSEQ), 3FC (SEQ), 400 (NONSEQ), 404 (SEQ).
- 4-beat read where the slave returns ERROR on beat 2 -> Htrans = IDLE the cycle after the first error cycle, done = 1 with err = 1, only one rdata_valid pulse.
- Hresetn = 0 mid-burst -> Htrans = 00 and Haddr = 0 after that edge, no done pulse, cmd_ready = 1.
